// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths and state encoding for the sobel_window slice.
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int TAP_W = 9;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;
endpackage

// File: rtl/sobel_window_if.sv
// sobel_window_if: pixel stream in, 3x3 window out; SOBEL_WIN_COORD_EN adds the centre coordinate.
interface sobel_window_if;
  import sobel_pkg::*;
  logic sof;
  logic pix_valid;
  logic [PIX_W-1:0] pix_in;
  logic [TAP_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic win_valid;
  logic busy;
`ifdef SOBEL_WIN_COORD_EN
  logic [CNT_W-1:0] win_row;
  logic [CNT_W-1:0] win_col;
`endif
  modport master (
    output sof, pix_valid, pix_in,
    input p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, busy
`ifdef SOBEL_WIN_COORD_EN
    , input win_row, win_col
`endif
  );
  modport slave (
    input sof, pix_valid, pix_in,
    output p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, busy
`ifdef SOBEL_WIN_COORD_EN
    , output win_row, win_col
`endif
  );
endinterface

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one-line delay, read-before-write at the current column address.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];
  assign dout_o = mem_q[addr_i];
  always_ff @(posedge clk)
    if (en_i) mem_q[addr_i] <= din_i;
endmodule

// File: rtl/sobel_window.sv
// sobel_window: 3x3 raster window generator over an IMG_W x IMG_H frame.
// Define SOBEL_WIN_COORD_EN to add win_row/win_col (window centre coordinate).
module sobel_window
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input logic clk,
  input logic rst_n,
  sobel_window_if.slave bus
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_R = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  state_e state_q;
  logic [CNT_W-1:0] row_q, col_q, r, c;
  logic [PIX_W-1:0] sh_q [3][2];
  logic [PIX_W-1:0] p_q [9];
  logic [PIX_W-1:0] col_in [3];
  logic [PIX_W-1:0] up1, up2;
  logic win_q, active, acc, win, eol;
  assign active = state_q == FILL || state_q == RUN;
  assign acc = bus.pix_valid && (bus.sof || active);
  // sof always restarts the frame, so it forces this pixel to (0,0)
  assign r = bus.sof ? '0 : row_q;
  assign c = bus.sof ? '0 : col_q;
  assign eol = c == LAST_C;
  assign win = acc && r >= TWO && c >= TWO;
  assign col_in = '{bus.pix_in, up1, up2};
  sobel_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .en_i(acc), .addr_i(c[AW-1:0]), .din_i(bus.pix_in), .dout_o(up1)
  );
  sobel_line_buf #(.DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .en_i(acc), .addr_i(c[AW-1:0]), .din_i(up1), .dout_o(up2)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      win_q <= 1'b0;
      sh_q <= '{default: '0};
      p_q <= '{default: '0};
    end else begin
      win_q <= win;
      if (acc) begin
        col_q <= eol ? '0 : c + 1'b1;
        row_q <= eol ? ((r == LAST_R) ? '0 : r + 1'b1) : r;
        state_q <= bus.sof ? FILL :
                   (state_q == FILL && eol && r == CNT_W'(1)) ? RUN :
                   (state_q == RUN && eol && r == LAST_R) ? DONE : state_q;
        // column history restarts at each line start so windows never straddle lines
        for (int k = 0; k < 3; k++) begin
          sh_q[k][0] <= col_in[k];
          sh_q[k][1] <= (c == '0) ? '0 : sh_q[k][0];
        end
      end
      if (win)
        p_q <= '{sh_q[2][1], sh_q[2][0], up2,
                 sh_q[1][1], sh_q[1][0], up1,
                 sh_q[0][1], sh_q[0][0], bus.pix_in};
    end
`ifdef SOBEL_WIN_COORD_EN
  logic [CNT_W-1:0] win_row_q, win_col_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (win) begin
      win_row_q <= r - 1'b1;
      win_col_q <= c - 1'b1;
    end
  assign bus.win_row = win_row_q;
  assign bus.win_col = win_col_q;
`endif
  assign bus.p0 = TAP_W'(p_q[0]);
  assign bus.p1 = TAP_W'(p_q[1]);
  assign bus.p2 = TAP_W'(p_q[2]);
  assign bus.p3 = TAP_W'(p_q[3]);
  assign bus.p4 = TAP_W'(p_q[4]);
  assign bus.p5 = TAP_W'(p_q[5]);
  assign bus.p6 = TAP_W'(p_q[6]);
  assign bus.p7 = TAP_W'(p_q[7]);
  assign bus.p8 = TAP_W'(p_q[8]);
  assign bus.win_valid = win_q;
  assign bus.busy = active;
endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: random-stimulus bench with a frame-array reference model for sobel_window.
module tb_sobel_window;
  localparam int W = 64;
  localparam int H = 48;
  localparam int NWIN = (W - 2) * (H - 2);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sobel_window_if s ();
  sobel_window_if b ();
  sobel_window #(.IMG_W(4), .IMG_H(3)) u_small (.clk(clk), .rst_n(rst_n), .bus(s.slave));
  sobel_window #(.IMG_W(W), .IMG_H(H)) u_big (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [7:0] img [H][W];
  logic [8:0] held [9];
  bit pend = 1'b0;
  bit cur_busy = 1'b0;
  int pr = 0;
  int pc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_taps(input string tag, input logic [8:0] e [9]);
    logic [8:0] got [9];
    got = '{b.p0, b.p1, b.p2, b.p3, b.p4, b.p5, b.p6, b.p7, b.p8};
    for (int k = 0; k < 9; k++) chk($sformatf("%s_p%0d", tag, k), 32'(got[k]), 32'(e[k]));
  endtask

  // check the previous cycle's expectation, then drive this cycle's inputs
  task automatic tick(input bit v, input bit sf, input logic [7:0] px, input bit ew,
                      input int er, input int ec, input bit eb);
    @(negedge clk);
    chk("win_valid", 32'(b.win_valid), 32'(pend));
    chk("busy", 32'(b.busy), 32'(cur_busy));
    if (pend) begin
      pulses++;
      for (int k = 0; k < 9; k++) held[k] = {1'b0, img[pr - 2 + k / 3][pc - 2 + k % 3]};
    end
    chk_taps("tap", held);
    b.pix_valid = v; b.sof = sf; b.pix_in = px;
    pend = ew; pr = er; pc = ec; cur_busy = eb;
  endtask

  task automatic frame(input int npix, input int pct, input bit ramp);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      logic [7:0] px;
      r = i / W;
      c = i % W;
      if (i > 0 && $urandom_range(99) < pct)
        tick(1'b0, 1'($urandom_range(1)), 8'($urandom), 1'b0, 0, 0, cur_busy);
      px = ramp ? 8'(i) : 8'($urandom);
      img[r][c] = px;
      tick(1'b1, i == 0, px, r >= 2 && c >= 2, r, c, i != W * H - 1);
    end
  endtask

  task automatic idle_discard(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'($urandom), 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [8:0] sg [9];
    s.pix_valid = 1'b0; s.sof = 1'b0; s.pix_in = '0;
    b.pix_valid = 1'b0; b.sof = 1'b0; b.pix_in = '0;
    for (int k = 0; k < 9; k++) held[k] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 4x3 frame with pixels 1..12 back to back
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("small_win_k%0d", k), 32'(s.win_valid), 32'(k == 11 || k == 12));
      chk($sformatf("small_busy_k%0d", k), 32'(s.busy), 32'(k >= 1 && k <= 11));
      sg = '{s.p0, s.p1, s.p2, s.p3, s.p4, s.p5, s.p6, s.p7, s.p8};
      for (int j = 0; j < 9; j++) begin
        int base;
        base = (k <= 10) ? -1 : (k == 11 ? 1 : 2);
        chk($sformatf("small_p%0d_k%0d", j, k), 32'(sg[j]),
            base < 0 ? 32'd0 : 32'(base + (j / 3) * 4 + j % 3));
      end
`ifdef SOBEL_WIN_COORD_EN
      if (k == 11 || k == 12) begin
        chk("small_row", 32'(s.win_row), 32'd1);
        chk("small_col", 32'(s.win_col), 32'(k - 10));
      end
`endif
      s.pix_valid = k < 12;
      s.sof = k == 0;
      s.pix_in = 8'(k + 1);
    end
    s.pix_valid = 1'b0;

    // ramp frame with random pixel gaps, then pixels in DONE without sof
    pulses = 0;
    frame(W * H, 40, 1'b1);
    tick(1'b0, 1'b0, 8'h0, 1'b0, 0, 0, 1'b0);
    idle_discard(6);
    chk("ramp_pulses", 32'(pulses), 32'(NWIN));

    // frame A aborted by sof at (1,5), frame B complete
    pulses = 0;
    frame(W + 5, 20, 1'b0);
    frame(W * H, 20, 1'b0);
    tick(1'b0, 1'b0, 8'h0, 1'b0, 0, 0, 1'b0);
    chk("abort_pulses", 32'(pulses), 32'(NWIN));

    // asynchronous reset at pixel (10,10)
    frame(10 * W + 10, 0, 1'b0);
    @(negedge clk);
    chk("pre_rst_win", 32'(b.win_valid), 32'd1);
    b.pix_valid = 1'b0; b.sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_win", 32'(b.win_valid), 32'd0);
    chk("rst_busy", 32'(b.busy), 32'd0);
    for (int k = 0; k < 9; k++) held[k] = '0;
    chk_taps("rst_tap", held);
    @(negedge clk);
    rst_n = 1'b1;
    pend = 1'b0; cur_busy = 1'b0;
    idle_discard(8);
    pulses = 0;
    frame(W * H, 30, 1'b0);
    tick(1'b0, 1'b0, 8'h0, 1'b0, 0, 0, 1'b0);
    chk("post_rst_pulses", 32'(pulses), 32'(NWIN));

    // two frames with sof on the cycle right after the last pixel
    pulses = 0;
    frame(W * H, 0, 1'b0);
    frame(W * H, 0, 1'b0);
    tick(1'b0, 1'b0, 8'h0, 1'b0, 0, 0, 1'b0);
    chk("b2b_pulses", 32'(pulses), 32'(2 * NWIN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter IMG_W, default 64, pixels per line (legal 4..1024).
REQ-002 Parameter IMG_H, default 48, lines per frame (legal 3..1024).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 sof  input  1  start-of-frame; qualified by pix_valid and marks the frame's first pixel.
REQ-006 pix_valid  input  1  pix_in valid this cycle; no backpressure.
REQ-007 pix_in  input  8  unsigned pixel, raster order.
REQ-008 p0..p8  output  9 each  3x3 window, zero-extended to 9 bits (bit 8 always 0).
REQ-009 win_valid  output  1  p0..p8 hold a complete interior window this cycle.
REQ-010 busy  output  1  frame in progress: between an accepted sof and the last pixel of the frame.

Function
REQ-011 Window layout: p0 p1 p2 = line r-2; p3 p4 p5 = line r-1; p6 p7 p8 = line r (current); left to right = columns c-2, c-1, c.
- p8 = pixel just accepted.
- p4 = centre, driven for completeness.
REQ-012 States:
- IDLE: wait for sof.
- FILL: rows 0..1.
- RUN: rows 2..IMG_H-1.
- DONE: frame complete.
REQ-013 Transitions:
- IDLE->FILL on pix_valid&sof.
- FILL->RUN after the last pixel of row 1.
- RUN->DONE after pixel (IMG_H-1, IMG_W-1).
- DONE->FILL on pix_valid&sof.
REQ-014 The column counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance only on accepted pixels; the column counter wraps to 0 and increments the row counter.
REQ-015 Two line buffers of IMG_W x 8 bits are written on every accepted pixel in FILL/RUN; a pixel written at column c is read back at column c one and two lines later.
REQ-016 Latency: win_valid is a registered output, high exactly one cycle after accepting pixel (r,c) with r>=2 and c>=2; p0..p8 update in that same cycle.
REQ-017 win_valid is low in all other cycles: pix_valid low, c<2, r<2, IDLE, DONE.
REQ-018 Each frame yields exactly (IMG_W-2)*(IMG_H-2) win_valid pulses.
REQ-019 Horizontal wrap: no window mixes columns of different lines; the column shift registers are restarted at c=0.
REQ-020 p0..p8 hold their last value while win_valid is low.
REQ-021 Pixels with pix_valid high in IDLE or DONE without sof are discarded.
REQ-022 sof mid-frame (FILL/RUN):
- abort the frame and restart counters at (0,0) with this pixel;
- go to FILL;
- no window from the aborted frame is emitted after the sof cycle.
REQ-023 busy is high in FILL and RUN, and low in IDLE and DONE.

Reset
REQ-024 On rst_n low: state=IDLE, counters=0, p0..p8=0, win_valid=0, busy=0, column shift registers=0.
REQ-025 Line buffer contents are not reset.
REQ-026 Reset mid-frame discards the frame; the next frame starts only at sof.

Configuration
REQ-027 Macro SOBEL_WIN_COORD_EN, when defined, adds outputs win_row[9:0] and win_col[9:0], giving the centre coordinate (r-1, c-1) of the current window; they are registered with win_valid and reset to 0.
REQ-028 Without SOBEL_WIN_COORD_EN these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package sobel_pkg holds: PIX_W=8, TAP_W=9, the state-encoding typedef, and the counter width constant CNT_W=10.
REQ-030 One sub-module, sobel_line_buf: a single-port-per-cycle delay line of depth IMG_W, instantiated twice.

Verification
REQ-031 IMG_W=4, IMG_H=3, pixels 1..12 continuous -> 2 win_valid pulses; first has p0..p8 = 1,2,3,5,6,7,9,10,11; second = 2,3,4,6,7,8,10,11,12.
REQ-032 Default size, ramp frame with pix_valid toggling randomly -> exactly 62*46=2852 pulses; windows match the golden model.
REQ-033 sof reasserted at pixel (1,5) of frame A, then a full frame B -> no window from frame A; B yields 2852 pulses.
REQ-034 rst_n low for 1 cycle at pixel (10,10) -> all outputs 0 immediately (asynchronous); pixels without sof are ignored; the next sof frame is correct.
REQ-035 Two back-to-back frames with sof on the cycle after the last pixel -> DONE->FILL with no lost pixel; both frames are correct.
REQ-036 With SOBEL_WIN_COORD_EN, on the 4x3 case of REQ-031 -> (win_row, win_col) = (1,1) then (1,2).
